spi_tx_fifo: RTL and testbench
==============================

# spi_tx_fifo

Transmit FIFO stage directly downstream of the SPI APB control decode. It captures every transmit-data write strobe, together with its frame payload and last-frame marker, into a synchronous circular buffer. It presents the oldest entry to the SPI shift engine in show-ahead form, reports fill level and status, and records overflow and underflow events as sticky flags until software clears them.

## Interface

Parameters:

- CFG_FRAME_SIZE, 4, width of one SPI frame in bits.
- FIFO_DEPTH, 4, number of entries; must be a power of two and at least 2.
- ADDR_W, log2(FIFO_DEPTH), pointer width; derived, never overridden.

Ports:

- pclk  in  1  system clock; all logic samples on its rising edge.
- preset  in  1  synchronous reset, active-high.
- tx_fifo_write  in  1  single-cycle push strobe from the control decode.
- tx_fifo_data  in  CFG_FRAME_SIZE  frame to push.
- tx_fifo_last  in  1  marks the pushed frame as the last of a transfer.
- tx_fifo_flush  in  1  discards all contents; sourced from the control-register clear bit.
- rd_en  in  1  pop strobe from the shift engine.
- rd_data  out  CFG_FRAME_SIZE  head entry payload.
- rd_last  out  1  head entry last-frame flag.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  ADDR_W+1  current number of entries.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop occurred while empty.
- status_clear  in  1  clears overflow and underflow.
- last_popped  out  1  registered one-cycle pulse after an entry with last=1 is popped.

## Operation

- Storage: FIFO_DEPTH words of CFG_FRAME_SIZE+1 bits (payload plus last flag); no reset on the storage array.
- State: wr_ptr and rd_ptr (ADDR_W bits, wrap modulo FIFO_DEPTH) and count (ADDR_W+1 bits); empty = (count==0), full = (count==FIFO_DEPTH).
- Push accepted when tx_fifo_write=1 and either full=0 or rd_en=1 in the same cycle.
  - Effect: write {tx_fifo_last, tx_fifo_data} at wr_ptr; wr_ptr+1.
- Pop accepted when rd_en=1 and empty=0.
  - Effect: rd_ptr+1.
- Count update: count+1 for a push only, count-1 for a pop only, unchanged for both or neither.
- Full with push and pop in the same cycle: both accepted, count stays FIFO_DEPTH, no overflow.
- Empty with push and pop in the same cycle: pop rejected and underflow set; push accepted; count becomes 1. There is no bypass from input to output.
- Push while full without rd_en: data dropped, pointers unchanged, overflow<=1.
- Pop while empty: pointers unchanged, underflow<=1.
- Flush (highest priority after reset): wr_ptr, rd_ptr and count <= 0. A push or pop in the same cycle is ignored and sets no flags. last_popped <= 0.
- Sticky flags: status_clear=1 clears overflow and underflow. If a new event occurs in the same cycle as status_clear, the set wins.
- rd_data/rd_last: combinationally show mem[rd_ptr]. Valid only while empty=0; contents are don't-care while empty.
- last_popped <= accepted pop AND rd_last (head value before the pop).

## Timing

- Reset (preset=1 at an edge): count=0, empty=1, full=0, overflow=0, underflow=0, last_popped=0, both pointers 0. Reset overrides flush and all strobes.
- Push latency: a push at edge N gives empty=0 and valid rd_data/rd_last immediately after edge N, so the shift engine can pop at edge N+1.
- Pop: at the edge where rd_en=1, the next head appears immediately after that edge. Back-to-back pops every cycle are supported.
- last_popped is high for exactly the cycle after the popping edge.
- full, empty, count, overflow and underflow are all registered-derived and change only at clock edges. No combinational path from the input strobes to status outputs.
- Throughput: one push and one pop per cycle sustained.

## Test plan

- Reset, then 4 pushes of 0x1,0x2,0x3,0x4 with last=0,0,0,1 (DEPTH=4) -> full=1, count=4; 4 pops return 0x1..0x4 in order; last_popped pulses only after the 4th pop; empty=1 at the end.
- Full FIFO, push 0x9 without rd_en -> overflow=1, count=4, contents unchanged. Same cycle push 0x9 with rd_en -> overflow stays 0, count=4, 0x9 becomes the tail.
- Empty FIFO, rd_en with a push of 0x5 in the same cycle -> underflow=1, count=1, rd_data=0x5 next cycle. status_clear -> underflow=0.
- Wrap: 10 cycles of simultaneous push/pop with count held at 2 -> data order preserved across pointer wrap; count constant at 2.
- Flush with 3 entries plus a push in the same cycle -> count=0, empty=1, no overflow. A subsequent push of 0x7 becomes the head.
- preset asserted mid-stream with count=3 -> all outputs at reset values after the next edge; the previous contents are never popped.

Source files
------------

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO between the SPI control decode and the shift engine: show-ahead
// circular buffer of {last, frame} entries with fill level and sticky error flags.
module spi_tx_fifo #(
  parameter int CFG_FRAME_SIZE = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int ADDR_W        = $clog2(FIFO_DEPTH)
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      tx_fifo_write,
  input  logic [CFG_FRAME_SIZE-1:0] tx_fifo_data,
  input  logic                      tx_fifo_last,
  input  logic                      tx_fifo_flush,
  input  logic                      rd_en,
  output logic [CFG_FRAME_SIZE-1:0] rd_data,
  output logic                      rd_last,
  output logic                      empty,
  output logic                      full,
  output logic [ADDR_W:0]           count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      status_clear,
  output logic                      last_popped
);

  logic [CFG_FRAME_SIZE:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_reg;
  logic [ADDR_W-1:0]       rd_ptr_reg;
  logic [ADDR_W:0]         count_reg;
  logic [ADDR_W:0]         count_next;
  logic                    overflow_reg;
  logic                    underflow_reg;
  logic                    last_popped_reg;

  logic push_ok;
  logic pop_ok;
  logic overflow_event;
  logic underflow_event;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (ADDR_W+1)'(FIFO_DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok         = tx_fifo_write && (!full || rd_en);
  assign pop_ok          = rd_en && !empty;
  assign overflow_event  = tx_fifo_write && full && !rd_en;
  assign underflow_event = rd_en && empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
      2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push_ok && !tx_fifo_flush) begin
      mem[wr_ptr_reg] <= {tx_fifo_last, tx_fifo_data};
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      last_popped_reg <= 1'b0;
    end else if (tx_fifo_flush) begin
      // Strobes coinciding with a flush are ignored and raise no flags.
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      last_popped_reg <= 1'b0;
      if (status_clear) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      count_reg       <= count_next;
      last_popped_reg <= pop_ok && rd_last;
      overflow_reg    <= overflow_event || (overflow_reg && !status_clear);
      underflow_reg   <= underflow_event || (underflow_reg && !status_clear);
    end
  end

  assign rd_data     = mem[rd_ptr_reg][CFG_FRAME_SIZE-1:0];
  assign rd_last     = mem[rd_ptr_reg][CFG_FRAME_SIZE];
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
  assign last_popped = last_popped_reg;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Bench for spi_tx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_tx_fifo;
  localparam int FS = 4;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          pclk = 1'b0;
  logic          preset;
  logic          tx_fifo_write;
  logic [FS-1:0] tx_fifo_data;
  logic          tx_fifo_last;
  logic          tx_fifo_flush;
  logic          rd_en;
  logic [FS-1:0] rd_data;
  logic          rd_last;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic          status_clear;
  logic          last_popped;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 pclk = ~pclk;

  spi_tx_fifo #(.CFG_FRAME_SIZE(FS), .FIFO_DEPTH(DEPTH)) dut (
    .pclk(pclk), .preset(preset), .tx_fifo_write(tx_fifo_write),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_last(tx_fifo_last),
    .tx_fifo_flush(tx_fifo_flush), .rd_en(rd_en), .rd_data(rd_data),
    .rd_last(rd_last), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow), .status_clear(status_clear),
    .last_popped(last_popped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last, data} plus flag bits.
  logic [FS:0] q[$];
  bit m_ovf, m_udf, m_lp;

  always @(posedge pclk) begin
    bit m_full, m_empty, m_pop, m_push;
    if (preset) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_lp = 0;
    end else if (tx_fifo_flush) begin
      q.delete();
      m_lp = 0;
      if (status_clear) begin m_ovf = 0; m_udf = 0; end
    end else begin
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      m_pop   = rd_en && !m_empty;
      m_push  = tx_fifo_write && (!m_full || rd_en);
      m_lp    = m_pop && q[0][FS];
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({tx_fifo_last, tx_fifo_data});
      m_ovf = (tx_fifo_write && m_full && !rd_en) || (m_ovf && !status_clear);
      m_udf = (rd_en && m_empty) || (m_udf && !status_clear);
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(q.size()));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
      check("last_popped", 32'(last_popped), 32'(m_lp));
      if (q.size() != 0) begin
        check("rd_data", 32'(rd_data), 32'(q[0][FS-1:0]));
        check("rd_last", 32'(rd_last), 32'(q[0][FS]));
      end
    end
  end

  // Apply one cycle of strobes, return #1 after the edge that consumed them.
  task automatic cyc(input bit w, input logic [FS-1:0] d, input bit l,
                     input bit r, input bit f, input bit c);
    tx_fifo_write = w; tx_fifo_data = d; tx_fifo_last = l;
    rd_en = r; tx_fifo_flush = f; status_clear = c;
    @(posedge pclk); #1;
    tx_fifo_write = 0; tx_fifo_last = 0; rd_en = 0;
    tx_fifo_flush = 0; status_clear = 0;
  endtask

  initial begin
    preset = 1; tx_fifo_write = 0; tx_fifo_data = '0; tx_fifo_last = 0;
    tx_fifo_flush = 0; rd_en = 0; status_clear = 0;
    cyc(0, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0, 0, 0);
    preset = 0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_flags", 32'({overflow, underflow, last_popped}), 0);

    // Fill with 1..4, last on the 4th, then drain in order.
    for (int i = 1; i <= 4; i++) cyc(1, FS'(i), i == 4, 0, 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_head", 32'(rd_data), 32'(i));
      cyc(0, 0, 0, 1, 0, 0);
      check("drain_lp", 32'(last_popped), 32'(i == 4));
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("lp_one_cycle", 32'(last_popped), 0);
    check("drain_empty", 32'(empty), 1);

    // Overflow, then simultaneous push/pop at full.
    for (int i = 1; i <= 4; i++) cyc(1, FS'(i), 0, 0, 0, 0);
    cyc(1, 4'h9, 0, 0, 0, 0);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_head", 32'(rd_data), 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("ovf_clear", 32'(overflow), 0);
    cyc(1, 4'h9, 0, 1, 0, 0);
    check("fullrw_ovf", 32'(overflow), 0);
    check("fullrw_count", 32'(count), 4);
    check("fullrw_head", 32'(rd_data), 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    check("fullrw_tail", 32'(rd_data), 9);
    cyc(0, 0, 0, 1, 0, 0);

    // Pop on empty with a push in the same cycle.
    cyc(1, 4'h5, 0, 1, 0, 0);
    check("udf_set", 32'(underflow), 1);
    check("udf_count", 32'(count), 1);
    check("udf_head", 32'(rd_data), 5);
    cyc(0, 0, 0, 0, 0, 1);
    check("udf_clear", 32'(underflow), 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Wrap: hold count at 2 through 10 push/pop cycles.
    cyc(1, 4'h0, 0, 0, 0, 0);
    cyc(1, 4'h1, 0, 0, 0, 0);
    for (int i = 2; i < 12; i++) begin
      cyc(1, FS'(i), 0, 1, 0, 0);
      check("wrap_count", 32'(count), 2);
      check("wrap_head", 32'(rd_data), 32'(i - 1));
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Flush with 3 entries and a coincident push.
    for (int i = 0; i < 3; i++) cyc(1, FS'(i + 3), 0, 0, 0, 0);
    cyc(1, 4'hA, 0, 0, 1, 0);
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_ovf", 32'(overflow), 0);
    cyc(1, 4'h7, 0, 0, 0, 0);
    check("flush_head", 32'(rd_data), 7);

    // Reset mid-stream with 3 entries.
    cyc(1, 4'h8, 1, 0, 0, 0);
    cyc(1, 4'hB, 0, 0, 0, 0);
    check("pre_rst_count", 32'(count), 3);
    preset = 1;
    cyc(0, 0, 0, 1, 0, 0);
    preset = 0;
    check("midrst_count", 32'(count), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_flags", 32'({overflow, underflow, last_popped, full}), 0);
    cyc(1, 4'hC, 0, 0, 0, 0);
    check("midrst_head", 32'(rd_data), 32'hC);
    cyc(0, 0, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      preset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 99) < 55, FS'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 5);
    end
    preset = 0;
    cyc(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
